// File: rtl/memory_in_seq_ctrl.sv
// Sequencer for the 64x8 sample memory: fills it from an input stream (LOAD), then
// replays the stored set in address order to the regression datapath (STREAM).
module memory_in_seq_ctrl #(
   parameter int DW    = 8,
   parameter int AW    = 6,
   parameter int DEPTH = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   input  logic          start,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   output logic          out_last,
   input  logic          out_ready,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   count,
   output logic [DW-1:0] mem_data,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_out
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOADED, S_STREAM} state_t;

   state_t        state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   rp_q, rp_d;
   logic          inflight_q, inflight_d;
   logic [AW:0]   inflight_addr_q, inflight_addr_d;
   logic [DW-1:0] buf_data_q [2];
   logic [DW-1:0] buf_data_d [2];
   logic          buf_last_q [2];
   logic          buf_last_d [2];
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    occ_q, occ_d;
   logic          done_q, done_d;

   logic          accept;
   logic          pop;
   logic          issue;
   logic [2:0]    pend;

   assign in_ready  = ((state_q == S_IDLE) || (state_q == S_LOAD)) && (count_q < DEPTH_C);
   assign accept    = in_valid && in_ready && !clear;
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = buf_data_q[rd_ptr_q];
   assign out_last  = out_valid && buf_last_q[rd_ptr_q];
   assign pop       = out_valid && out_ready;
   // Slots committed after this edge; counting the pop keeps 1 sample/cycle.
   assign pend      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = (state_q == S_STREAM) && (rp_q < count_q) && (pend < 3'd2) && !clear;

   assign mem_wr    = accept;
   assign mem_data  = accept ? in_data : '0;
   assign mem_addr  = accept ? count_q[AW-1:0] : (issue ? rp_q[AW-1:0] : '0);
   assign busy      = ((state_q == S_LOAD) && (count_q != '0)) || (state_q == S_STREAM);
   assign done      = done_q;
   assign count     = count_q;

   always_comb begin
      state_d         = state_q;
      count_d         = count_q;
      rp_d            = rp_q;
      inflight_d      = 1'b0;
      inflight_addr_d = inflight_addr_q;
      buf_data_d      = buf_data_q;
      buf_last_d      = buf_last_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      occ_d           = occ_q;
      done_d          = 1'b0;

      case (state_q)
         S_IDLE, S_LOAD: begin
            if (accept) begin
               count_d = count_q + (AW+1)'(1);
               if (in_last || (count_d == DEPTH_C)) state_d = S_LOADED;
               else                                 state_d = S_LOAD;
            end
         end
         S_LOADED: begin
            if (start) begin
               state_d = S_STREAM;
               rp_d    = '0;
            end
         end
         S_STREAM: begin
            if (issue) begin
               rp_d            = rp_q + (AW+1)'(1);
               inflight_d      = 1'b1;
               inflight_addr_d = rp_q;
            end
            if (inflight_q) begin
               buf_data_d[wr_ptr_q] = mem_out;
               buf_last_d[wr_ptr_q] = (inflight_addr_q == (count_q - (AW+1)'(1)));
               wr_ptr_d             = ~wr_ptr_q;
            end
            if (pop) rd_ptr_d = ~rd_ptr_q;
            occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
            if (pop && out_last) begin
               state_d    = S_LOADED;
               done_d     = 1'b1;
               occ_d      = 2'd0;
               inflight_d = 1'b0;
               wr_ptr_d   = 1'b0;
               rd_ptr_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // clear overrides everything, including a same-cycle start or sample.
      if (clear) begin
         state_d    = S_IDLE;
         count_d    = '0;
         rp_d       = '0;
         inflight_d = 1'b0;
         occ_d      = 2'd0;
         wr_ptr_d   = 1'b0;
         rd_ptr_d   = 1'b0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         count_q         <= '0;
         rp_q            <= '0;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
         buf_data_q      <= '{default: '0};
         buf_last_q      <= '{default: 1'b0};
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         occ_q           <= 2'd0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         rp_q            <= rp_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
         buf_data_q      <= buf_data_d;
         buf_last_q      <= buf_last_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         occ_q           <= occ_d;
         done_q          <= done_d;
      end
   end

endmodule

// File: tb/tb_memory_in_seq_ctrl.sv
// Directed bench for memory_in_seq_ctrl with a behavioural 64x8 memory, a write
// scoreboard and a stream scoreboard ({last,data}) fed from the loaded-set model.
module tb_memory_in_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic       start = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ready = 1'b0;
   logic       busy;
   logic       done;
   logic [6:0] count;
   logic [7:0] mem_data;
   logic [5:0] mem_addr;
   logic       mem_wr;
   logic [7:0] mem_out;

   int total = 0;
   int bad   = 0;

   logic [8:0]  exp_q[$];
   logic [13:0] wr_q[$];
   logic [7:0]  model_set [64];
   int          mcount = 0;

   logic [7:0] mem [64];
   logic       prev_last_hs = 1'b0;
   logic       prev_stall = 1'b0;
   logic [7:0] held_data = '0;

   memory_in_seq_ctrl dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .start(start),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .done(done), .count(count),
      .mem_data(mem_data), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_out(mem_out)
   );

   always #5 clk = ~clk;

   initial for (int i = 0; i < 64; i++) mem[i] = '0;

   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr] <= mem_data;
      mem_out <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_last_hs = 1'b0;
         prev_stall   = 1'b0;
      end else begin
         chk("done_pulse", 32'(done), 32'(prev_last_hs));
         if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(held_data));
         end
         if (mem_wr) begin
            chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
               logic [13:0] w;
               w = wr_q.pop_front();
               chk("wr_addr", 32'(mem_addr), 32'(w[13:8]));
               chk("wr_data", 32'(mem_data), 32'(w[7:0]));
            end
         end
         if (out_valid && out_ready) begin
            chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               logic [8:0] e;
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(e[7:0]));
               chk("out_last", 32'(out_last), 32'(e[8]));
            end
         end
         prev_last_hs = out_valid && out_ready && out_last && !clear;
         prev_stall   = out_valid && !out_ready && !clear;
         held_data    = out_data;
      end
   end

   task automatic load(input logic [7:0] d, input logic last);
      chk("load_in_ready", 32'(in_ready), 32'(mcount < 64));
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      if (mcount < 64) begin
         wr_q.push_back({6'(mcount), d});
         model_set[mcount] = d;
         mcount++;
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic start_stream();
      for (int i = 0; i < mcount; i++) exp_q.push_back({(i == mcount - 1), model_set[i]});
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      exp_q.delete();
      mcount = 0;
      tick();
      clear = 1'b0;
   endtask

   // mode 0: ready always, 1: ready pattern 1,0,0 repeating, 2: random ready
   task automatic run_stream(input int mode, input int budget);
      int n;
      n = 0;
      while (n < budget) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((n % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         tick();
         n++;
         if (done) break;
      end
      chk("done_in_budget", 32'(done), 32'd1);
      chk("stream_drained", 32'(exp_q.size()), 32'd0);
      out_ready = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_last"}, 32'(out_last), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_data"}, 32'(mem_data), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      // reset
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst_held");
      rst = 1'b0;
      tick();
      check_reset_outputs("rst_rel");

      // load three samples
      load(8'h01, 1'b0);
      chk("load_busy", 32'(busy), 32'd1);
      load(8'h02, 1'b0);
      load(8'h03, 1'b1);
      chk("loaded3_count", 32'(count), 32'd3);
      chk("loaded3_in_ready", 32'(in_ready), 32'd0);
      chk("loaded3_busy", 32'(busy), 32'd0);

      // full-rate stream, cycle-exact
      out_ready = 1'b1;
      start_stream();
      chk("lat_c0_valid", 32'(out_valid), 32'd0);
      chk("stream_busy", 32'(busy), 32'd1);
      tick();
      chk("lat_c1_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("burst_valid", 32'(out_valid), 32'd1);
      end
      tick();
      chk("done_after_last", 32'(done), 32'd1);
      chk("restream_count", 32'(count), 32'd3);
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);

      // stream with stalls
      start_stream();
      run_stream(1, 40);

      // 64 samples without in_last
      do_clear();
      chk("clear_count", 32'(count), 32'd0);
      chk("clear_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 64; i++) load(8'($urandom_range(0, 255)), 1'b0);
      chk("full_count", 32'(count), 32'd64);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      in_data  = 8'hEE;
      in_valid = 1'b1;
      #1;
      chk("sample65_in_ready", 32'(in_ready), 32'd0);
      chk("sample65_mem_wr", 32'(mem_wr), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("full_count_hold", 32'(count), 32'd64);
      start_stream();
      run_stream(2, 400);

      // clear mid-stream after the first sample
      out_ready = 1'b1;
      start_stream();
      tick();
      tick();
      chk("clr_first_valid", 32'(out_valid), 32'd1);
      tick();
      out_ready = 1'b0;
      do_clear();
      out_ready = 1'b1;
      chk("clr_out_valid", 32'(out_valid), 32'd0);
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_in_ready", 32'(in_ready), 32'd1);
      chk("clr_busy", 32'(busy), 32'd0);
      load(8'h04, 1'b1);
      chk("reload_count", 32'(count), 32'd1);
      start_stream();
      run_stream(0, 20);

      // rst mid-load
      do_clear();
      load(8'h10, 1'b0);
      load(8'h11, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      tick();
      rst = 1'b0;
      mcount = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("post_rst_no_stream", 32'(out_valid), 32'd0);
         chk("post_rst_idle", 32'(busy), 32'd0);
         tick();
      end
      load(8'h21, 1'b0);
      load(8'h22, 1'b1);
      start_stream();
      run_stream(2, 40);
      chk("wr_drained", 32'(wr_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
